// File: rtl/spi_arb_seq_if.sv
// spi_arb_seq_if: requester handshake and spi0 pin bundle for spi_arb_seq.
interface spi_arb_seq_if;
   logic       req0, req1, rnw0, rnw1;
   logic [4:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       ack0, ack1;
   logic [7:0] rdata;
   logic       spi_SCLK, spi_MOSI, spi_SS_n, spi_MISO;
   modport master (
      output req0, req1, rnw0, rnw1, addr0, addr1, wdata0, wdata1, spi_MISO,
      input  ack0, ack1, rdata, spi_SCLK, spi_MOSI, spi_SS_n
   );
   modport slave (
      input  req0, req1, rnw0, rnw1, addr0, addr1, wdata0, wdata1, spi_MISO,
      output ack0, ack1, rdata, spi_SCLK, spi_MOSI, spi_SS_n
   );
endinterface

// File: rtl/spi_arb_seq.sv
// spi_arb_seq: two-requester round-robin arbiter sequencing 16-bit mode-0 SPI register accesses.
// Define SPI_ARB_STATUS_EN to expose the first MISO byte on the status port.
module spi_arb_seq #(
   parameter int CLK_DIV = 4
) (
   input logic         clk,
   input logic         reset,
   spi_arb_seq_if.slave bus
`ifdef SPI_ARB_STATUS_EN
   ,
   output logic [7:0]  status
`endif
);
   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE, GAP} state_t;
`ifdef SPI_ARB_STATUS_EN
   localparam int RXW = 16;
`else
   localparam int RXW = 8;
`endif
   state_t           state_q, state_d;
   logic [7:0]       div_q, div_d, rdata_q, rdata_d;
   logic [4:0]       bit_q, bit_d;
   logic [15:0]      tx_q, tx_d;
   logic [RXW-1:0]   rx_q, rx_d;
   logic [1:0]       ack_q, ack_d;
   logic             sclk_q, sclk_d, ss_n_q, ss_n_d, last_q, last_d, gnt_q, gnt_d;
   logic             tick, pick, rnw;
   logic [4:0]       addr;
   logic [7:0]       wdata;
`ifdef SPI_ARB_STATUS_EN
   logic [7:0]       stat_q, stat_d;
   assign status = stat_q;
`endif
   assign tick  = div_q == 8'(CLK_DIV - 1);
   // Tie goes to whoever was not served last; a lone request is served directly.
   assign pick  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
   assign rnw   = pick ? bus.rnw1 : bus.rnw0;
   assign addr  = pick ? bus.addr1 : bus.addr0;
   assign wdata = pick ? bus.wdata1 : bus.wdata0;
   always_comb begin
      state_d = state_q;
      div_d   = (state_q == IDLE || state_q == DONE || tick) ? 8'd0 : div_q + 8'd1;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      sclk_d  = sclk_q;
      ss_n_d  = ss_n_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      ack_d   = 2'b00;
      rdata_d = rdata_q;
`ifdef SPI_ARB_STATUS_EN
      stat_d  = stat_q;
`endif
      case (state_q)
         IDLE: if (bus.req0 || bus.req1) begin
            state_d = SETUP;
            ss_n_d  = 1'b0;
            gnt_d   = pick;
            last_d  = pick;
            tx_d    = {addr, 1'b0, ~rnw, 1'b0, rnw ? 8'h00 : wdata};
         end
         SETUP: if (tick) state_d = XFER;
         // Odd toggles are rises (sample MISO), even toggles are falls (advance MOSI).
         XFER: if (tick) begin
            sclk_d  = ~sclk_q;
            bit_d   = bit_q + 5'd1;
            tx_d    = sclk_q ? {tx_q[14:0], 1'b0} : tx_q;
            rx_d    = sclk_q ? rx_q : {rx_q[RXW-2:0], bus.spi_MISO};
            state_d = bit_q == 5'd31 ? HOLD : XFER;
         end
         HOLD: if (tick) begin
            state_d = DONE;
            ss_n_d  = 1'b1;
         end
         DONE: begin
            state_d = GAP;
            ack_d   = gnt_q ? 2'b10 : 2'b01;
            rdata_d = rx_q[7:0];
`ifdef SPI_ARB_STATUS_EN
            stat_d  = rx_q[15:8];
`endif
         end
         GAP: if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         sclk_q  <= 1'b0;
         ss_n_q  <= 1'b1;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         ack_q   <= '0;
         rdata_q <= '0;
`ifdef SPI_ARB_STATUS_EN
         stat_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         sclk_q  <= sclk_d;
         ss_n_q  <= ss_n_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
`ifdef SPI_ARB_STATUS_EN
         stat_q  <= stat_d;
`endif
      end
   end
   // The shifter empties on the 16th fall, so MOSI is already 0 whenever SS_n is high.
   assign bus.spi_MOSI = tx_q[15];
   assign bus.spi_SCLK = sclk_q;
   assign bus.spi_SS_n = ss_n_q;
   assign bus.ack0     = ack_q[0];
   assign bus.ack1     = ack_q[1];
   assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_spi_arb_seq.sv
// tb_spi_arb_seq: directed self-checking bench for spi_arb_seq at CLK_DIV=2 with a mode-0 SPI slave model.
module tb_spi_arb_seq;
   localparam int D = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   spi_arb_seq_if bus();
`ifdef SPI_ARB_STATUS_EN
   logic [7:0] status;
`endif
   spi_arb_seq #(.CLK_DIV(D)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef SPI_ARB_STATUS_EN
      ,
      .status(status)
`endif
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;
   int pass = 0, total = 0;
   int n_ack = 0, ss_low = 0, ss_rise = 0, mosi_viol = 0;
   int ack_id [32];
   int ack_cyc[32];
   logic ss_prev = 1'b1;
   always @(negedge clk) begin
      if (bus.ack0 || bus.ack1) begin
         if (n_ack < 32) begin
            ack_id[n_ack]  = bus.ack1 ? 1 : 0;
            ack_cyc[n_ack] = cyc;
         end
         n_ack++;
      end
      if (!bus.spi_SS_n) ss_low++;
      if (bus.spi_SS_n && bus.spi_MOSI) mosi_viol++;
      if (bus.spi_SS_n && !ss_prev) ss_rise++;
      ss_prev = bus.spi_SS_n;
   end
   // Slave model: MISO presents bit 15 at SS_n fall and advances on each SCLK fall.
   logic [15:0] miso_word = 16'h0000, mosi_cap = 16'h0000;
   logic [3:0]  fcnt = 4'd0;
   always @(negedge bus.spi_SCLK or posedge bus.spi_SS_n) fcnt = bus.spi_SS_n ? 4'd0 : fcnt + 4'd1;
   assign bus.spi_MISO = miso_word[4'd15 - fcnt];
   always @(posedge bus.spi_SCLK) mosi_cap = {mosi_cap[14:0], bus.spi_MOSI};
   task automatic req(input bit id, input bit r, input logic [4:0] a, input logic [7:0] w);
      if (id) begin
         bus.rnw1 = r; bus.addr1 = a; bus.wdata1 = w; bus.req1 = 1'b1;
      end else begin
         bus.rnw0 = r; bus.addr0 = a; bus.wdata0 = w; bus.req0 = 1'b1;
      end
   endtask
   task automatic wait_acks(input int n, input bit hold);
      int target;
      target = n_ack + n;
      for (int i = 0; i < 600 && n_ack < target; i++) begin
         @(negedge clk); #1;
         if (!hold && bus.ack0) bus.req0 = 1'b0;
         if (!hold && bus.ack1) bus.req1 = 1'b0;
         if (hold && n_ack >= target) begin
            bus.req0 = 1'b0; bus.req1 = 1'b0;
         end
      end
   endtask
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus.spi_SS_n !== 1'b1) $display("FAIL reset_ss_n: got %b want 1", bus.spi_SS_n); else pass++;
      total++; if (bus.spi_SCLK !== 1'b0) $display("FAIL reset_sclk: got %b want 0", bus.spi_SCLK); else pass++;
      total++; if (bus.spi_MOSI !== 1'b0) $display("FAIL reset_mosi: got %b want 0", bus.spi_MOSI); else pass++;
      total++; if ({bus.ack1, bus.ack0} !== 2'b00) $display("FAIL reset_ack: got %b want 00", {bus.ack1, bus.ack0}); else pass++;
      total++; if (bus.rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", bus.rdata); else pass++;
      reset = 1'b0;
   endtask
   task automatic test_tie;
      int c, b, r;
      b = n_ack; r = ss_rise; c = cyc;
      miso_word = 16'h3C42;
      req(1'b0, 1'b0, 5'h11, 8'hA5);
      req(1'b1, 1'b1, 5'h19, 8'hEE);
      wait_acks(2, 1'b0);
      total++; if (n_ack - b !== 2) $display("FAIL tie_acks: got %0d want 2", n_ack - b); else pass++;
      total++; if (ack_id[b] !== 0) $display("FAIL tie_first: got %0d want 0", ack_id[b]); else pass++;
      total++; if (ack_id[b+1] !== 1) $display("FAIL tie_second: got %0d want 1", ack_id[b+1]); else pass++;
      total++; if (ack_cyc[b] - c !== 70) $display("FAIL tie_latency0: got %0d want 70", ack_cyc[b] - c); else pass++;
      total++; if (ack_cyc[b+1] - ack_cyc[b] !== 72) $display("FAIL tie_spacing: got %0d want 72", ack_cyc[b+1] - ack_cyc[b]); else pass++;
      total++; if (ss_rise - r !== 2) $display("FAIL tie_ss_rises: got %0d want 2", ss_rise - r); else pass++;
      total++; if (mosi_cap !== 16'hC800) $display("FAIL tie_mosi1: got %h want c800", mosi_cap); else pass++;
      total++; if (bus.rdata !== 8'h42) $display("FAIL tie_rdata: got %h want 42", bus.rdata); else pass++;
   endtask
   task automatic test_alternate;
      int b;
      idle(5);
      b = n_ack;
      req(1'b0, 1'b0, 5'h02, 8'h11);
      req(1'b1, 1'b0, 5'h03, 8'h22);
      wait_acks(4, 1'b1);
      total++; if (n_ack - b !== 4) $display("FAIL alt_acks: got %0d want 4", n_ack - b); else pass++;
      for (int i = 0; i < 4; i++) begin
         total++; if (ack_id[b+i] !== i % 2) $display("FAIL alt_grant%0d: got %0d want %0d", i, ack_id[b+i], i % 2); else pass++;
      end
   endtask
   task automatic test_write;
      int b, c, s;
      idle(5);
      miso_word = 16'h0000;
      b = n_ack; c = cyc; s = ss_low;
      req(1'b0, 1'b0, 5'h11, 8'hA5);
      wait_acks(1, 1'b0);
      total++; if (n_ack - b !== 1) $display("FAIL wr_acks: got %0d want 1", n_ack - b); else pass++;
      total++; if (ack_id[b] !== 0) $display("FAIL wr_id: got %0d want 0", ack_id[b]); else pass++;
      total++; if (ack_cyc[b] - c !== 70) $display("FAIL wr_latency: got %0d want 70", ack_cyc[b] - c); else pass++;
      total++; if (ss_low - s !== 68) $display("FAIL wr_ss_low: got %0d want 68", ss_low - s); else pass++;
      total++; if (mosi_cap !== 16'h8AA5) $display("FAIL wr_mosi: got %h want 8aa5", mosi_cap); else pass++;
      total++; if (bus.rdata !== 8'h00) $display("FAIL wr_rdata: got %h want 00", bus.rdata); else pass++;
   endtask
   task automatic test_read;
      int b, c;
      idle(5);
      miso_word = 16'h3C42;
      b = n_ack; c = cyc;
      req(1'b1, 1'b1, 5'h19, 8'h77);
      wait_acks(1, 1'b0);
      total++; if (ack_id[b] !== 1) $display("FAIL rd_id: got %0d want 1", ack_id[b]); else pass++;
      total++; if (ack_cyc[b] - c !== 70) $display("FAIL rd_latency: got %0d want 70", ack_cyc[b] - c); else pass++;
      total++; if (mosi_cap !== 16'hC800) $display("FAIL rd_mosi: got %h want c800", mosi_cap); else pass++;
      total++; if (bus.rdata !== 8'h42) $display("FAIL rd_rdata: got %h want 42", bus.rdata); else pass++;
`ifdef SPI_ARB_STATUS_EN
      total++; if (status !== 8'h3C) $display("FAIL rd_status: got %h want 3c", status); else pass++;
`endif
   endtask
   task automatic test_drop;
      int b, c;
      idle(5);
      miso_word = 16'h0099;
      b = n_ack; c = cyc;
      req(1'b0, 1'b0, 5'h04, 8'h5C);
      while (cyc < c + 13) @(negedge clk);
      bus.req0 = 1'b0; bus.addr0 = 5'h1F; bus.wdata0 = 8'hFF;
      idle(120);
      total++; if (n_ack - b !== 1) $display("FAIL drop_acks: got %0d want 1", n_ack - b); else pass++;
      total++; if (ack_cyc[b] - c !== 70) $display("FAIL drop_latency: got %0d want 70", ack_cyc[b] - c); else pass++;
      total++; if (mosi_cap !== 16'h225C) $display("FAIL drop_mosi: got %h want 225c", mosi_cap); else pass++;
      total++; if (bus.rdata !== 8'h99) $display("FAIL drop_rdata: got %h want 99", bus.rdata); else pass++;
   endtask
   task automatic test_reset_mid;
      int b, c;
      idle(5);
      b = n_ack; c = cyc;
      req(1'b0, 1'b0, 5'h11, 8'hA5);
      while (cyc < c + 3 + 4 * D * 7 / 2) @(negedge clk);
      #1;
      reset = 1'b1; bus.req0 = 1'b0;
      #1;
      total++; if (bus.spi_SS_n !== 1'b1) $display("FAIL rst_mid_ss_n: got %b want 1", bus.spi_SS_n); else pass++;
      total++; if (bus.spi_SCLK !== 1'b0) $display("FAIL rst_mid_sclk: got %b want 0", bus.spi_SCLK); else pass++;
      idle(3);
      reset = 1'b0;
      idle(80);
      total++; if (n_ack - b !== 0) $display("FAIL rst_mid_no_ack: got %0d want 0", n_ack - b); else pass++;
      total++; if (bus.rdata !== 8'h00) $display("FAIL rst_mid_rdata: got %h want 00", bus.rdata); else pass++;
      b = n_ack; c = cyc;
      req(1'b0, 1'b0, 5'h11, 8'hA5);
      wait_acks(1, 1'b0);
      total++; if (ack_cyc[b] - c !== 70) $display("FAIL rst_mid_after_latency: got %0d want 70", ack_cyc[b] - c); else pass++;
      total++; if (mosi_cap !== 16'h8AA5) $display("FAIL rst_mid_after_mosi: got %h want 8aa5", mosi_cap); else pass++;
   endtask
   initial begin
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rnw0 = 1'b0; bus.rnw1 = 1'b0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      test_reset;
      test_tie;
      test_alternate;
      test_write;
      test_read;
      test_drop;
      test_reset_mid;
      total++; if (mosi_viol !== 0) $display("FAIL mosi_idle: got %0d want 0", mosi_viol); else pass++;
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/spi_arb_seq.md
SPI_ARB_SEQ -- requirements
Module: spi_arb_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have port clk  input  1  system clock; every flop samples on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  transaction request from requester 0/1; held high until the matching ack.
REQ-005 SHALL have ports rnw0/rnw1  input  1  1 = register read, 0 = register write.
REQ-006 SHALL have ports addr0/addr1  input  5  USB controller register number.
REQ-007 SHALL have ports wdata0/wdata1  input  8  write data; don't-care on reads.
REQ-008 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse to requester 0/1.
REQ-009 SHALL have port rdata  output  8  second MISO byte of the last transaction; valid in the ack cycle and held until the next ack.
REQ-010 SHALL have ports spi_SCLK, spi_MOSI, spi_SS_n  output  1 each, and spi_MISO  input  1; these connect to the spi0 pins.

Function
REQ-011 SHALL use states IDLE, SETUP, XFER, HOLD, DONE, GAP.
REQ-012 IDLE: with any req high, SHALL grant one requester, latch its rnw/addr/wdata and go to SETUP on the next edge.
REQ-013 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; the last-grant register resets to 1, so req0 wins the first tie.
REQ-014 Command byte SHALL be {addr[4:0], 1'b0, ~rnw, 1'b0}, sent MSB first, followed by wdata (write) or 8'h00 (read); 16 bits total.
REQ-015 SETUP: spi_SS_n low, spi_SCLK low, MOSI driving bit 15, for CLK_DIV cycles, then go to XFER.
REQ-016 XFER: SPI mode 0; SCLK toggles every CLK_DIV cycles; MISO sampled on each SCLK rise; MOSI advances on each SCLK fall; after the 16th rise and CLK_DIV further cycles, SCLK is low and the state goes to HOLD.
REQ-017 HOLD: SS_n low, SCLK low for CLK_DIV cycles, then SS_n high and go to DONE.
REQ-018 DONE: one cycle; pulse ack of the granted requester; load rdata with MISO bits 7:0.
REQ-019 GAP: SS_n high for CLK_DIV cycles, then IDLE; requests are not granted during GAP.
REQ-020 ack SHALL occur exactly 34*CLK_DIV+2 cycles after the IDLE cycle in which the grant was made.
REQ-021 A requester dropping req mid-transaction SHALL NOT abort it; ack still pulses.
REQ-022 Inputs of the ungranted requester SHALL be ignored until the next IDLE.
REQ-023 spi_MOSI SHALL be 0 whenever spi_SS_n is high.

Reset
REQ-024 Reset SHALL force IDLE, spi_SS_n=1, spi_SCLK=0, spi_MOSI=0, ack0=ack1=0, rdata=8'h00, last-grant=1, bit counter=0, divider=0.
REQ-025 Reset mid-transaction SHALL raise spi_SS_n immediately (asynchronously) and emit no ack for the aborted transfer.

Configuration
REQ-026 Macro SPI_ARB_STATUS_EN: when defined, SHALL add output port status (8 bits), loaded in DONE with MISO bits 15:8 (USB controller status byte) and reset to 8'h00.
REQ-027 Without SPI_ARB_STATUS_EN, SHALL discard MISO bits 15:8; the status port SHALL NOT exist; all other behaviour identical.

Verification
REQ-028 CLK_DIV=2, req0 write addr=5'h11, wdata=8'hA5 -> MOSI stream 8'h8A,8'hA5; SS_n low 68 cycles; ack0 at cycle 70 after grant.
REQ-029 req1 read addr=5'h19, MISO model returns 8'h3C,8'h42 -> MOSI 8'hC8,8'h00; rdata=8'h42 at ack1; status=8'h3C when SPI_ARB_STATUS_EN defined.
REQ-030 req0 and req1 raised in the same cycle out of reset -> req0 served first, req1 granted after GAP, no SS_n glitch between transactions.
REQ-031 req0 held continuously while req1 pending -> grants alternate 0,1,0,1 across four transactions.
REQ-032 Reset asserted at bit 7 of XFER -> SS_n high in the same cycle; no ack pulse; next req0 completes normally.
REQ-033 req0 dropped after 10 cycles of XFER -> transaction completes; ack0 pulses exactly once.
